write_back_stage: RTL and testbench
===================================

// Module: write_back_stage
// PURPOSE
//  Registered MEM/WB stage plus write-back datapath for the pipelined MIPS core.
//  - Latches MEM-stage results into the MEM/WB pipeline register, which supports stall and flush.
//  - Aligns and sign/zero-extends load data (LW/LH/LHU/LB/LBU).
//  - Holds the architectural HI/LO registers.
//  - Drives the register-file write port.
// PARAMETERS
//  DATA_W     32  datapath width; multiple of 8; byte offset width OFF_W = $clog2(DATA_W/8)
//  REG_ADDR_W 5   register-file address width
//  HILO_EN    1   1: HI/LO registers present; 0: hi_w/lo_w tied 0, sel HI/LO returns 0
// PORTS
//  clk                    in  1          rising-edge clock
//  rst                    in  1          asynchronous reset, active-high
//  stall_w                in  1          hold MEM/WB register and HI/LO
//  flush_w                in  1          load bubble into MEM/WB (valid_w<=0)
//  valid_m                in  1          MEM-stage instruction valid
//  reg_write_m            in  1          instruction writes register file
//  reg_write_data_sel_m   in  2          00 ALU lo, 01 load data, 10 HI reg, 11 LO reg
//  mem_load_type_m        in  3          000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others = LW
//  mem_byte_off_m         in  OFF_W      byte address of load within word
//  data_mem_read_data_m   in  DATA_W     raw data-memory word
//  alu_result_lo_m        in  DATA_W     ALU result / mult-div low half
//  alu_result_hi_m        in  DATA_W     mult-div high half
//  hilo_write_m           in  1          instruction updates HI/LO (MULT/DIV/MTHI/MTLO merged)
//  reg_file_write_addr_m  in  REG_ADDR_W destination register
//  valid_w                out 1          WB-stage instruction valid
//  reg_file_write_en_w    out 1          register-file write strobe
//  reg_file_write_addr_w  out REG_ADDR_W registered destination
//  reg_file_write_data_w  out DATA_W     selected write-back data (also forwarding source)
//  hi_w, lo_w             out DATA_W     architectural HI/LO
// BEHAVIOUR
//  - Reset (async, rst=1): MEM/WB register, valid_w, hi_w, lo_w = 0.
//    Hence reg_file_write_en_w=0, addr=0, data=0.
//  - Each posedge with rst=0: flush_w=1 -> valid_w<=0, other fields <=0 (flush beats stall).
//    Else stall_w=1 -> hold all. Else capture all *_m inputs into *_w.
//  - Latency: 1 cycle M->W. Write-back data is combinational from the registered fields
//    and the current hi_w/lo_w.
//  - reg_file_write_en_w = valid_w & reg_write_w & (reg_file_write_addr_w != 0).
//    Writes to $0 are suppressed.
//  - Load extraction, byte lane k = off * 8:
//    - LB/LBU: byte k sign/zero-extended.
//    - LH/LHU: halfword at {off[OFF_W-1:1],1'b0}; off[0] ignored (no misalign trap here).
//    - LW: whole word; off ignored.
//  - HI/LO commit: at the posedge ending a WB cycle with valid_w & hilo_write_w & !stall_w
//    & !rst: hi_w<=alu_hi_w, lo_w<=alu_lo_w.
//    - A flush in the same cycle does not cancel a commit already in WB.
//  - An MFHI/MFLO directly following MULT reaches WB after the commit edge and reads the new
//    value; no HI/LO bypass is required.
//  - Stalled WB instruction: reg write strobe stays asserted (idempotent); HI/LO not
//    re-committed until released.
//  - Reset asserted mid-stall or mid-commit: all state cleared immediately; no partial write.
// STRUCTURE
//  - mips_pkg holds the WB_SEL_* codes (ALU, MEM, HI, LO) and the LD_* load-type codes.
//  - Sub-module load_extend (combinational lane select plus extension), parametrised by
//    DATA_W.
//  - Data select reuses mux4_1 #(DATA_W).
// TESTING
//  1. rst pulse mid-cycle -> all outputs 0 asynchronously; en_w=0 for the first cycle after
//     release.
//  2. LB, off=3, mem=32'h80FF_1234 -> data_w=32'hFFFF_FF80. LBU -> 32'h0000_0080.
//     LH, off=2 -> 32'hFFFF_80FF.
//  3. MULT (hilo_write, hi=32'h1, lo=32'h2), then MFHI sel=10, then MFLO sel=11
//     -> data_w 32'h1 then 32'h2.
//  4. stall_w=1 for 3 cycles holding an ALU write (addr 5, 32'hDEAD) -> outputs stable,
//     en_w=1 throughout. flush+stall together -> valid_w=0.
//  5. reg_write_m=1, addr=0 -> en_w=0. valid_m=0 with hilo_write_m=1 -> hi/lo unchanged.
//  6. HILO_EN=0 build: MULT then MFHI -> data_w=0, hi_w=lo_w=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core pipeline: write-back source select and load types.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_HI  = 2'b10,
    WB_SEL_LO  = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } ld_type_e;

endpackage

// File: rtl/load_extend.sv
// Load data lane selection and sign/zero extension for LW/LH/LHU/LB/LBU.
module load_extend
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] raw_data,
  input  logic [2:0]        load_type,
  input  logic [OFF_W-1:0]  byte_off,
  output logic [DATA_W-1:0] load_data
);

  logic [OFF_W-1:0]  half_off;
  logic [DATA_W-1:0] byte_shift;
  logic [DATA_W-1:0] half_shift;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // Halfword loads ignore the low offset bit; misalignment is trapped upstream.
  assign half_off   = byte_off & ~OFF_W'(1);
  assign byte_shift = raw_data >> {byte_off, 3'b000};
  assign half_shift = raw_data >> {half_off, 3'b000};
  assign byte_v     = byte_shift[7:0];
  assign half_v     = half_shift[15:0];

  always_comb begin
    load_data = raw_data;
    case (load_type)
      LD_LH:   load_data = {{(DATA_W-16){half_v[15]}}, half_v};
      LD_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_v};
      LD_LB:   load_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LD_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_v};
      default: load_data = raw_data;
    endcase
  end

endmodule

// File: rtl/mux4_1.sv
// Generic 4:1 multiplexer.
module mux4_1 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic [W-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register with stall/flush, load extension, HI/LO registers
// and the register-file write port.
module write_back_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int HILO_EN    = 1,
  localparam int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_w,
  input  logic                  flush_w,
  input  logic                  valid_m,
  input  logic                  reg_write_m,
  input  logic [1:0]            reg_write_data_sel_m,
  input  logic [2:0]            mem_load_type_m,
  input  logic [OFF_W-1:0]      mem_byte_off_m,
  input  logic [DATA_W-1:0]     data_mem_read_data_m,
  input  logic [DATA_W-1:0]     alu_result_lo_m,
  input  logic [DATA_W-1:0]     alu_result_hi_m,
  input  logic                  hilo_write_m,
  input  logic [REG_ADDR_W-1:0] reg_file_write_addr_m,
  output logic                  valid_w,
  output logic                  reg_file_write_en_w,
  output logic [REG_ADDR_W-1:0] reg_file_write_addr_w,
  output logic [DATA_W-1:0]     reg_file_write_data_w,
  output logic [DATA_W-1:0]     hi_w,
  output logic [DATA_W-1:0]     lo_w
);

  logic                  reg_write_w;
  logic [1:0]            sel_w;
  logic [2:0]            load_type_w;
  logic [OFF_W-1:0]      byte_off_w;
  logic [DATA_W-1:0]     mem_data_w;
  logic [DATA_W-1:0]     alu_lo_w;
  logic [DATA_W-1:0]     alu_hi_w;
  logic                  hilo_write_w;
  logic [DATA_W-1:0]     load_data_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush_w) begin
      valid_w               <= 1'b0;
      reg_write_w           <= 1'b0;
      sel_w                 <= '0;
      load_type_w           <= '0;
      byte_off_w            <= '0;
      mem_data_w            <= '0;
      alu_lo_w              <= '0;
      alu_hi_w              <= '0;
      hilo_write_w          <= 1'b0;
      reg_file_write_addr_w <= '0;
    end else if (!stall_w) begin
      valid_w               <= valid_m;
      reg_write_w           <= reg_write_m;
      sel_w                 <= reg_write_data_sel_m;
      load_type_w           <= mem_load_type_m;
      byte_off_w            <= mem_byte_off_m;
      mem_data_w            <= data_mem_read_data_m;
      alu_lo_w              <= alu_result_lo_m;
      alu_hi_w              <= alu_result_hi_m;
      hilo_write_w          <= hilo_write_m;
      reg_file_write_addr_w <= reg_file_write_addr_m;
    end
  end

  // HI/LO commit at the edge leaving WB; a simultaneous flush only affects the incoming slot.
  if (HILO_EN != 0) begin : g_hilo
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hi_q <= '0;
        lo_q <= '0;
      end else if (valid_w && hilo_write_w && !stall_w) begin
        hi_q <= alu_hi_w;
        lo_q <= alu_lo_w;
      end
    end

    assign hi_w = hi_q;
    assign lo_w = lo_q;
  end else begin : g_no_hilo
    assign hi_w = '0;
    assign lo_w = '0;
  end

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .raw_data  (mem_data_w),
    .load_type (load_type_w),
    .byte_off  (byte_off_w),
    .load_data (load_data_w)
  );

  mux4_1 #(
    .W (DATA_W)
  ) u_wb_mux (
    .sel (sel_w),
    .in0 (alu_lo_w),
    .in1 (load_data_w),
    .in2 (hi_w),
    .in3 (lo_w),
    .out (reg_file_write_data_w)
  );

  assign reg_file_write_en_w = valid_w && reg_write_w && (reg_file_write_addr_w != '0);

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the WB slot and HI/LO.
module tb_write_back_stage;

  logic        clk;
  logic        rst;
  logic        stall_w, flush_w, valid_m, reg_write_m, hilo_write_m;
  logic [1:0]  reg_write_data_sel_m;
  logic [2:0]  mem_load_type_m;
  logic [1:0]  mem_byte_off_m;
  logic [31:0] data_mem_read_data_m, alu_result_lo_m, alu_result_hi_m;
  logic [4:0]  reg_file_write_addr_m;

  logic        valid_w, en_w;
  logic [4:0]  addr_w;
  logic [31:0] data_w, hi_w, lo_w;
  logic        nh_valid_w, nh_en_w;
  logic [4:0]  nh_addr_w;
  logic [31:0] nh_data_w, nh_hi_w, nh_lo_w;

  int n_pass = 0;
  int n_total = 0;

  write_back_stage #(.DATA_W(32), .REG_ADDR_W(5), .HILO_EN(1)) dut (
    .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w), .valid_m(valid_m),
    .reg_write_m(reg_write_m), .reg_write_data_sel_m(reg_write_data_sel_m),
    .mem_load_type_m(mem_load_type_m), .mem_byte_off_m(mem_byte_off_m),
    .data_mem_read_data_m(data_mem_read_data_m), .alu_result_lo_m(alu_result_lo_m),
    .alu_result_hi_m(alu_result_hi_m), .hilo_write_m(hilo_write_m),
    .reg_file_write_addr_m(reg_file_write_addr_m), .valid_w(valid_w),
    .reg_file_write_en_w(en_w), .reg_file_write_addr_w(addr_w),
    .reg_file_write_data_w(data_w), .hi_w(hi_w), .lo_w(lo_w)
  );

  write_back_stage #(.DATA_W(32), .REG_ADDR_W(5), .HILO_EN(0)) dut_nohilo (
    .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w), .valid_m(valid_m),
    .reg_write_m(reg_write_m), .reg_write_data_sel_m(reg_write_data_sel_m),
    .mem_load_type_m(mem_load_type_m), .mem_byte_off_m(mem_byte_off_m),
    .data_mem_read_data_m(data_mem_read_data_m), .alu_result_lo_m(alu_result_lo_m),
    .alu_result_hi_m(alu_result_hi_m), .hilo_write_m(hilo_write_m),
    .reg_file_write_addr_m(reg_file_write_addr_m), .valid_w(nh_valid_w),
    .reg_file_write_en_w(nh_en_w), .reg_file_write_addr_w(nh_addr_w),
    .reg_file_write_data_w(nh_data_w), .hi_w(nh_hi_w), .lo_w(nh_lo_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction occupying WB plus the architectural HI/LO.
  typedef struct {
    bit        v, rw, hw;
    bit [1:0]  sel;
    bit [2:0]  lt;
    bit [1:0]  off;
    bit [31:0] mem, lo, hi;
    bit [4:0]  addr;
  } wb_t;

  wb_t       mdl;
  bit [31:0] m_hi, m_lo;

  function automatic bit [31:0] exp_load();
    bit [31:0] bw, hw;
    bw = mdl.mem >> (int'(mdl.off) * 8);
    hw = mdl.mem >> ((int'(mdl.off) / 2) * 16);
    case (mdl.lt)
      3'd1:    return hw[15] ? (hw & 32'hFFFF) | 32'hFFFF_0000 : hw & 32'hFFFF;
      3'd2:    return hw & 32'hFFFF;
      3'd3:    return bw[7] ? (bw & 32'hFF) | 32'hFFFF_FF00 : bw & 32'hFF;
      3'd4:    return bw & 32'hFF;
      default: return mdl.mem;
    endcase
  endfunction

  function automatic bit [31:0] exp_data();
    case (mdl.sel)
      2'd0:    return mdl.lo;
      2'd1:    return exp_load();
      2'd2:    return m_hi;
      default: return m_lo;
    endcase
  endfunction

  function automatic bit exp_en();
    return mdl.v && mdl.rw && (mdl.addr != 0);
  endfunction

  task automatic model_reset();
    mdl  = '{default: 0};
    m_hi = 0;
    m_lo = 0;
  endtask

  // Advance one clock, keeping the model in step; returns #1 after the edge.
  task automatic tick();
    wb_t nxt;
    bit  commit;
    commit = mdl.v && mdl.hw && !stall_w;
    nxt = mdl;
    if (flush_w) nxt = '{default: 0};
    else if (!stall_w)
      nxt = '{v: valid_m, rw: reg_write_m, hw: hilo_write_m, sel: reg_write_data_sel_m,
              lt: mem_load_type_m, off: mem_byte_off_m, mem: data_mem_read_data_m,
              lo: alu_result_lo_m, hi: alu_result_hi_m, addr: reg_file_write_addr_m};
    @(posedge clk);
    if (commit) begin
      m_hi = mdl.hi;
      m_lo = mdl.lo;
    end
    mdl = nxt;
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input bit [1:0] sel, input bit [2:0] lt,
                       input bit [1:0] off, input bit [31:0] mem, input bit [31:0] lo,
                       input bit [31:0] hi, input bit hw, input bit [4:0] addr);
    valid_m = v; reg_write_m = rw; reg_write_data_sel_m = sel; mem_load_type_m = lt;
    mem_byte_off_m = off; data_mem_read_data_m = mem; alu_result_lo_m = lo;
    alu_result_hi_m = hi; hilo_write_m = hw; reg_file_write_addr_m = addr;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_w = 0; flush_w = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    n_total++; if ({valid_w, en_w, addr_w, data_w, hi_w, lo_w} !== '0)
      $display("FAIL reset_hold: got v=%b en=%b a=%0d d=%h hi=%h lo=%h, want all 0",
               valid_w, en_w, addr_w, data_w, hi_w, lo_w); else n_pass++;
    rst = 1'b0;
    n_total++; if (en_w !== 1'b0) $display("FAIL reset_release_en: got %b want 0", en_w); else n_pass++;
    drive(1, 1, 0, 0, 0, 0, 32'h1111, 32'h2222, 1, 5'd7);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_total++; if (hi_w !== 32'h2222) $display("FAIL reset_pre_hi: got %h want 00002222", hi_w); else n_pass++;
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_total++; if ({valid_w, en_w, addr_w, data_w, hi_w, lo_w} !== '0)
      $display("FAIL reset_async: got v=%b en=%b a=%0d d=%h hi=%h lo=%h, want all 0",
               valid_w, en_w, addr_w, data_w, hi_w, lo_w); else n_pass++;
    #1 rst = 1'b0;
    n_total++; if (en_w !== 1'b0) $display("FAIL reset_first_cycle_en: got %b want 0", en_w); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_load_extend();
    drive(1, 1, 2'b01, 3'd3, 2'd3, 32'h80FF_1234, 0, 0, 0, 5'd9);
    tick();
    n_total++; if (data_w !== 32'hFFFF_FF80) $display("FAIL lb_off3: got %h want ffffff80", data_w); else n_pass++;
    drive(1, 1, 2'b01, 3'd4, 2'd3, 32'h80FF_1234, 0, 0, 0, 5'd9);
    tick();
    n_total++; if (data_w !== 32'h0000_0080) $display("FAIL lbu_off3: got %h want 00000080", data_w); else n_pass++;
    drive(1, 1, 2'b01, 3'd1, 2'd2, 32'h80FF_1234, 0, 0, 0, 5'd9);
    tick();
    n_total++; if (data_w !== 32'hFFFF_80FF) $display("FAIL lh_off2: got %h want ffff80ff", data_w); else n_pass++;
    drive(1, 1, 2'b01, 3'd2, 2'd1, 32'h80FF_1234, 0, 0, 0, 5'd9);
    tick();
    n_total++; if (data_w !== 32'h0000_1234) $display("FAIL lhu_off1: got %h want 00001234", data_w); else n_pass++;
    drive(1, 1, 2'b01, 3'd7, 2'd2, 32'h80FF_1234, 0, 0, 0, 5'd9);
    tick();
    n_total++; if (data_w !== 32'h80FF_1234) $display("FAIL ld_other_is_lw: got %h want 80ff1234", data_w); else n_pass++;
  endtask

  task automatic test_mult_mfhi();
    drive(1, 0, 2'b00, 0, 0, 0, 32'h2, 32'h1, 1, 5'd0);
    tick();
    drive(1, 1, 2'b10, 0, 0, 0, 0, 0, 0, 5'd3);
    tick();
    n_total++; if (data_w !== 32'h1) $display("FAIL mfhi_after_mult: got %h want 00000001", data_w); else n_pass++;
    drive(1, 1, 2'b11, 0, 0, 0, 0, 0, 0, 5'd4);
    tick();
    n_total++; if (data_w !== 32'h2) $display("FAIL mflo_after_mult: got %h want 00000002", data_w); else n_pass++;
    n_total++; if ({hi_w, lo_w} !== {32'h1, 32'h2}) $display("FAIL hilo_commit: got hi=%h lo=%h want 1/2", hi_w, lo_w); else n_pass++;
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 2'b00, 0, 0, 0, 32'hDEAD, 0, 0, 5'd5);
    tick();
    stall_w = 1'b1;
    drive(1, 1, 2'b00, 0, 0, 0, 32'hBEEF, 32'h77, 1, 5'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if ({valid_w, en_w, addr_w, data_w} !== {1'b1, 1'b1, 5'd5, 32'hDEAD})
        $display("FAIL stall_hold%0d: got v=%b en=%b a=%0d d=%h want 1/1/5/0000dead",
                 i, valid_w, en_w, addr_w, data_w); else n_pass++;
    end
    flush_w = 1'b1;
    tick();
    n_total++; if ({valid_w, en_w} !== 2'b00) $display("FAIL flush_beats_stall: got v=%b en=%b want 0/0", valid_w, en_w); else n_pass++;
    stall_w = 0; flush_w = 0;
    // A HI/LO writer in WB still commits when the next slot is flushed.
    drive(1, 0, 0, 0, 0, 0, 32'h55, 32'h66, 1, 0);
    tick();
    flush_w = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    flush_w = 1'b0;
    n_total++; if ({hi_w, lo_w} !== {32'h66, 32'h55}) $display("FAIL commit_with_flush: got hi=%h lo=%h want 66/55", hi_w, lo_w); else n_pass++;
    drive(1, 0, 0, 0, 0, 0, 32'h2, 32'h1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_zero_addr_invalid();
    drive(1, 1, 2'b00, 0, 0, 0, 32'h1234, 0, 0, 5'd0);
    tick();
    n_total++; if ({valid_w, en_w} !== 2'b10) $display("FAIL write_r0: got v=%b en=%b want 1/0", valid_w, en_w); else n_pass++;
    drive(0, 1, 2'b00, 0, 0, 0, 32'hBBBB, 32'hAAAA, 1, 5'd8);
    tick();
    n_total++; if (en_w !== 1'b0) $display("FAIL invalid_no_write: got en=%b want 0", en_w); else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_total++; if ({hi_w, lo_w} !== {32'h1, 32'h2}) $display("FAIL invalid_no_hilo: got hi=%h lo=%h want 1/2", hi_w, lo_w); else n_pass++;
  endtask

  task automatic test_hilo_disabled();
    drive(1, 0, 2'b00, 0, 0, 0, 32'h2, 32'h1, 1, 5'd0);
    tick();
    drive(1, 1, 2'b10, 0, 0, 0, 0, 0, 0, 5'd3);
    tick();
    n_total++; if (nh_data_w !== 32'h0) $display("FAIL nohilo_mfhi: got %h want 0", nh_data_w); else n_pass++;
    n_total++; if ({nh_hi_w, nh_lo_w} !== 64'h0) $display("FAIL nohilo_regs: got hi=%h lo=%h want 0/0", nh_hi_w, nh_lo_w); else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall_w = ($urandom_range(0, 4) == 0);
      flush_w = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));
      tick();
      n_total++; if (valid_w !== mdl.v) $display("FAIL rnd_valid cyc%0d: got %b want %b", i, valid_w, mdl.v); else n_pass++;
      n_total++; if (en_w !== exp_en()) $display("FAIL rnd_en cyc%0d: got %b want %b", i, en_w, exp_en()); else n_pass++;
      n_total++; if (addr_w !== mdl.addr) $display("FAIL rnd_addr cyc%0d: got %0d want %0d", i, addr_w, mdl.addr); else n_pass++;
      n_total++; if (data_w !== exp_data()) $display("FAIL rnd_data cyc%0d: got %h want %h", i, data_w, exp_data()); else n_pass++;
      n_total++; if ({hi_w, lo_w} !== {m_hi, m_lo})
        $display("FAIL rnd_hilo cyc%0d: got %h/%h want %h/%h", i, hi_w, lo_w, m_hi, m_lo); else n_pass++;
    end
    stall_w = 0; flush_w = 0;
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 1, 2'b00, 0, 0, 0, 32'h9, 32'h8, 1, 5'd2);
    tick();
    stall_w = 1'b1;
    tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_total++; if ({valid_w, en_w, data_w, hi_w, lo_w} !== '0)
      $display("FAIL reset_mid_stall: got v=%b en=%b d=%h hi=%h lo=%h want all 0",
               valid_w, en_w, data_w, hi_w, lo_w); else n_pass++;
    stall_w = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    tick();
    n_total++; if ({hi_w, lo_w} !== 64'h0) $display("FAIL no_partial_commit: got hi=%h lo=%h want 0/0", hi_w, lo_w); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_extend();
    test_mult_mfhi();
    test_stall_flush();
    test_zero_addr_invalid();
    test_hilo_disabled();
    test_random();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
